// File: rtl/score_window_buffer.sv
// 3x3 score window generator: two line buffers feed a column shift register,
// producing a registered interior neighbourhood plus centre coordinates.
module score_window_buffer #(
  parameter int DATA_BITS    = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int X_BITS       = $clog2(IMAGE_WIDTH),
  parameter int Y_BITS       = $clog2(IMAGE_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic signed [DATA_BITS-1:0] in_data,
  output logic signed [DATA_BITS-1:0] window [3][3],
  output logic                        out_valid,
  output logic [X_BITS-1:0]           out_x,
  output logic [Y_BITS-1:0]           out_y,
  output logic                        out_eof
);

  localparam logic [X_BITS-1:0] C_LAST = X_BITS'(IMAGE_WIDTH - 1);
  localparam logic [Y_BITS-1:0] R_LAST = Y_BITS'(IMAGE_HEIGHT - 1);
  localparam logic [X_BITS-1:0] C_TWO  = X_BITS'(2);
  localparam logic [Y_BITS-1:0] R_TWO  = Y_BITS'(2);

  logic [X_BITS-1:0] col_q, col_d, c_cur;
  logic [Y_BITS-1:0] row_q, row_d, r_cur;

  logic signed [DATA_BITS-1:0] lb0_q [IMAGE_WIDTH];
  logic signed [DATA_BITS-1:0] lb1_q [IMAGE_WIDTH];
  logic signed [DATA_BITS-1:0] win_q [3][3];
  logic signed [DATA_BITS-1:0] new_col [3];

  logic              valid_q, eof_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;

  // in_sof forces the accepted pixel to (0,0); the counters resync from there.
  always_comb begin
    c_cur = in_sof ? '0 : col_q;
    r_cur = in_sof ? '0 : row_q;
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (c_cur == C_LAST) begin
        col_d = '0;
        row_d = (r_cur == R_LAST) ? '0 : r_cur + Y_BITS'(1);
      end else begin
        col_d = c_cur + X_BITS'(1);
        row_d = r_cur;
      end
    end
    new_col[0] = lb1_q[c_cur];
    new_col[1] = lb0_q[c_cur];
    new_col[2] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= in_valid && (r_cur >= R_TWO) && (c_cur >= C_TWO);
      eof_q   <= in_valid && (c_cur == C_LAST) && (r_cur == R_LAST);
      if (in_valid) begin
        x_q <= c_cur - X_BITS'(1);
        y_q <= r_cur - Y_BITS'(1);
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
          win_q[i][2] <= new_col[i];
        end
      end
    end
  end

  // Line storage is never reset; stale rows are masked by the r>=2 gate.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[c_cur] <= lb0_q[c_cur];
      lb0_q[c_cur] <= in_data;
    end
  end

  assign window    = win_q;
  assign out_valid = valid_q;
  assign out_eof   = eof_q;
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_score_window_buffer.sv
// Bench for score_window_buffer: image-array reference model checked every
// cycle, plus literal expectations for frame framing, borders, resets and sign.
module tb_score_window_buffer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 16;
  localparam int XB = $clog2(W);
  localparam int YB = $clog2(H);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_sof = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic signed [DW-1:0] window [3][3];
  logic                 out_valid;
  logic [XB-1:0]        out_x;
  logic [YB-1:0]        out_y;
  logic                 out_eof;

  score_window_buffer #(
    .DATA_BITS(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .window(window), .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: the image as a 2-D array, coordinates tracked as plain ints.
  int mc = 0, mr = 0, cc = 0, rr = 0;
  logic signed [DW-1:0] img [H][W];
  logic signed [DW-1:0] exp_win [3][3];
  bit                   exp_valid = 0, exp_eof = 0, win_known = 1;
  logic [XB-1:0]        exp_x = '0;
  logic [YB-1:0]        exp_y = '0;

  task automatic model_reset();
    mc = 0; mr = 0;
    exp_valid = 0; exp_eof = 0; exp_x = '0; exp_y = '0; win_known = 1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) exp_win[i][j] = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic signed [DW-1:0] d);
    exp_valid = 0;
    exp_eof = 0;
    if (v) begin
      cc = s ? 0 : mc;
      rr = s ? 0 : mr;
      img[rr][cc] = d;
      exp_x = XB'(cc - 1);
      exp_y = YB'(rr - 1);
      exp_valid = (rr >= 2) && (cc >= 2);
      exp_eof = (cc == W - 1) && (rr == H - 1);
      win_known = exp_valid;
      if (exp_valid)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) exp_win[i][j] = img[rr - 2 + i][cc - 2 + j];
      if (cc == W - 1) begin
        mc = 0;
        mr = (rr == H - 1) ? 0 : rr + 1;
      end else begin
        mc = cc + 1;
        mr = rr;
      end
    end
  endtask

  // Statistics recorded from the DUT's valid windows for the literal checks.
  int nvalid = 0, neof = 0, arm = 0;
  int f00 = 0, f01 = 0, f11 = 0, f22 = 0, fx = 0, fy = 0;
  int lastx = 0, lasty = 0, last_eof = 0, m00 = 0, m20 = 0;

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(exp_valid));
    chk("out_eof", int'(out_eof), int'(exp_eof));
    chk("out_x", int'(out_x), int'(exp_x));
    chk("out_y", int'(out_y), int'(exp_y));
    if (win_known)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("window[%0d][%0d]", i, j), int'(window[i][j]), int'(exp_win[i][j]));
    if (out_valid) begin
      nvalid <= nvalid + 1;
      if (nvalid == arm) begin
        f00 <= window[0][0]; f01 <= window[0][1];
        f11 <= window[1][1]; f22 <= window[2][2];
        fx <= out_x; fy <= out_y;
      end
      lastx <= out_x; lasty <= out_y; last_eof <= out_eof;
      if (out_x == XB'(1) && out_y == YB'(2)) begin
        m00 <= window[0][0];
        m20 <= window[2][0];
      end
    end
    if (out_eof) neof <= neof + 1;
  end

  task automatic pix(input bit v, input bit s, input logic signed [DW-1:0] d);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    model_step(v, s, d);
    @(negedge clk);
  endtask

  task automatic frame(input bit sof, input bit gaps, input bit alt, input int npix);
    for (int k = 0; k < npix; k++) begin
      int r;
      int c;
      logic signed [DW-1:0] d;
      r = k / W;
      c = k % W;
      if (alt) d = (c % 2 == 1) ? 16'sh7FFF : 16'sh8000;
      else     d = DW'(r * 16 + c);
      pix(1'b1, sof && (k == 0), d);
      if (gaps) pix(1'b0, 1'b0, '0);
    end
  endtask

  int base_v, base_e;

  task automatic mark();
    base_v = nvalid;
    base_e = neof;
    arm = nvalid;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_eof", int'(out_eof), 0);
    chk("reset_x", int'(out_x), 0);
    chk("reset_y", int'(out_y), 0);
    chk("reset_w11", int'(window[1][1]), 0);
    rst = 1'b0;
    pix(1'b0, 1'b0, '0);

    // Continuous frame with in_sof on the first pixel.
    mark();
    frame(1'b1, 1'b0, 1'b0, W * H);
    pix(1'b0, 1'b0, '0);
    pix(1'b0, 1'b0, '0);
    chk("s1_count", nvalid - base_v, 24);
    chk("s1_eof_count", neof - base_e, 1);
    chk("s1_first_x", fx, 1);
    chk("s1_first_y", fy, 1);
    chk("s1_first_w11", f11, 17);
    chk("s1_first_w00", f00, 0);
    chk("s1_first_w22", f22, 34);
    chk("s1_last_x", lastx, 6);
    chk("s1_last_y", lasty, 4);
    chk("s1_last_eof", last_eof, 1);
    chk("s1_row3_w00", m00, 16);
    chk("s1_row3_w20", m20, 48);

    // Same frame with in_valid alternating.
    mark();
    frame(1'b1, 1'b1, 1'b0, W * H);
    pix(1'b0, 1'b0, '0);
    chk("s2_count", nvalid - base_v, 24);
    chk("s2_eof_count", neof - base_e, 1);
    chk("s2_first_w11", f11, 17);
    chk("s2_last_x", lastx, 6);
    chk("s2_last_y", lasty, 4);

    // Frame abandoned by in_sof at what would be pixel (5,3).
    mark();
    frame(1'b1, 1'b0, 1'b0, 3 * W + 5);
    pix(1'b0, 1'b0, '0);
    chk("s4_partial_count", nvalid - base_v, 9);
    chk("s4_partial_eof", neof - base_e, 0);
    mark();
    frame(1'b1, 1'b0, 1'b0, W * H);
    pix(1'b0, 1'b0, '0);
    chk("s4_count", nvalid - base_v, 24);
    chk("s4_eof_count", neof - base_e, 1);
    chk("s4_first_x", fx, 1);
    chk("s4_first_w11", f11, 17);
    chk("s4_first_w22", f22, 34);

    // Asynchronous reset between clock edges, mid row 3.
    frame(1'b1, 1'b0, 1'b0, 3 * W + 4);
    in_valid = 1'b0;
    in_sof = 1'b0;
    chk("s5_pre_rst_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("s5_rst_valid", int'(out_valid), 0);
    chk("s5_rst_x", int'(out_x), 0);
    chk("s5_rst_y", int'(out_y), 0);
    chk("s5_rst_w00", int'(window[0][0]), 0);
    chk("s5_rst_w11", int'(window[1][1]), 0);
    chk("s5_rst_w22", int'(window[2][2]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mark();
    frame(1'b0, 1'b0, 1'b0, W * H);
    pix(1'b0, 1'b0, '0);
    chk("s5_count", nvalid - base_v, 24);
    chk("s5_eof_count", neof - base_e, 1);
    chk("s5_first_w11", f11, 17);
    chk("s5_last_x", lastx, 6);

    // Extreme signed values pass through untouched.
    mark();
    frame(1'b1, 1'b0, 1'b1, W * H);
    pix(1'b0, 1'b0, '0);
    chk("s6_count", nvalid - base_v, 24);
    chk("s6_first_w00", f00, -32768);
    chk("s6_first_w01", f01, 32767);
    chk("s6_first_w11", f11, 32767);
    chk("s6_first_w22", f22, -32768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
